// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based hazard unit for the in-order pipeline.
// Tracks in-flight destinations after ID, produces forwarding selects,
// load-use stalls, redirect squash control and saturating event counters.
module hazard_ctrl #(
    parameter int REG_AW        = 5,
    parameter int DEPTH         = 3,
    parameter int LOAD_STAGE    = 2,
    parameter int RESOLVE_STAGE = 2,
    parameter int CNT_W         = 16,
    parameter int FW            = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              enable,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              redirect,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Scoreboard: index 0 is the youngest entry (EX), DEPTH-1 the oldest.
    logic [DEPTH-1:0]             sb_valid;
    logic [DEPTH-1:0]             sb_rw;
    logic [DEPTH-1:0]             sb_mr;
    logic [DEPTH-1:0][REG_AW-1:0] sb_dst;

    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] squash;
    logic [FW-1:0]    sel_a;
    logic [FW-1:0]    sel_b;
    logic             found_a;
    logic             found_b;
    logic             ld_a;
    logic             ld_b;
    logic             haz_a;
    logic             haz_b;
    logic             hazard;
    logic             push_id;

    // An entry can supply a value only if it will actually write a nonzero register.
    always_comb begin
        live = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            live[k] = sb_valid[k] && sb_rw[k] && (sb_dst[k] != '0);
        end
    end

    // Youngest-match search for each source; the first hit in index order wins,
    // so an older ALU result can never mask a younger, not-yet-ready load.
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found_a && id_valid && id_uses_rs && live[k] && (sb_dst[k] == id_rs)) begin
                found_a = 1'b1;
                sel_a   = FW'(k + 1);
                ld_a    = sb_mr[k] && (k < unsigned'(LOAD_STAGE));
            end
            if (!found_b && id_valid && id_uses_rt && live[k] && (sb_dst[k] == id_rt)) begin
                found_b = 1'b1;
                sel_b   = FW'(k + 1);
                ld_b    = sb_mr[k] && (k < unsigned'(LOAD_STAGE));
            end
        end
    end

    // Hazard resolution and pipeline control; redirect overrides any load-use stall.
    always_comb begin
        haz_a   = found_a && ld_a;
        haz_b   = found_b && ld_b;
        hazard  = haz_a || haz_b;
        fwd_a   = haz_a ? '0 : sel_a;
        fwd_b   = haz_b ? '0 : sel_b;
        stall   = enable && !redirect && hazard;
        bubble  = stall;
        flush   = enable && redirect && !arst;
        push_id = id_valid && !hazard && !redirect;
        squash  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            squash[k] = redirect && (k < unsigned'(RESOLVE_STAGE));
        end
    end

    // Scoreboard shift in lock-step with the pipeline; squash applies post-shift.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sb_valid <= '0;
            sb_rw    <= '0;
            sb_mr    <= '0;
            sb_dst   <= '0;
        end else if (enable) begin
            sb_valid[0] <= push_id && !squash[0];
            sb_rw[0]    <= id_reg_write;
            sb_mr[0]    <= id_mem_read;
            sb_dst[0]   <= id_dst;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                sb_valid[k] <= sb_valid[k-1] && !squash[k];
                sb_rw[k]    <= sb_rw[k-1];
                sb_mr[k]    <= sb_mr[k-1];
                sb_dst[k]   <= sb_dst[k-1];
            end
        end
    end

    // Saturating performance counters for stalls and redirects.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (enable) begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
